// File: rtl/uart_pkg.sv
// Shared types, defaults and helpers for the parametrised UART transmitter.
//   tx_state_t : transmitter FSM states
//   par_bit()  : parity of up to MAX_DATA_BITS data bits, optionally inverted for odd parity
package uart_pkg;

  localparam int unsigned DEF_BAUD_DIV  = 2604;
  localparam int unsigned DEF_DATA_BITS = 8;
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  // Unused upper bits must be zero; zero bits do not change the XOR.
  function automatic logic par_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Producer-side valid/ready handshake of the UART transmitter.
//   tx_data  : word to send
//   tx_valid : producer offers tx_data
//   tx_ready : transmitter FIFO can accept a word this cycle
interface uart_tx_fifo_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset (discards contents)
//   i_push     : write i_data (ignored when full)
//   i_pop      : drop the head entry (ignored when empty)
//   o_head     : current head entry
//   o_count    : occupancy, one bit wider than the pointers
//   o_full     : o_count == DEPTH
//   o_empty    : o_count == 0
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CountFull);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input FIFO.
//   clk, rst_n   : clock, asynchronous active-low reset (aborts any frame, tx high at once)
//   i_bus        : producer handshake (tx_data / tx_valid / tx_ready)
//   o_tx         : serial line, idle high, driven straight from a flop
//   o_tx_busy    : high while a frame is on the line
//   o_tx_done    : one-cycle pulse after the last stop bit of each frame
//   o_fifo_count : FIFO occupancy
// Frame: start, DATA_BITS data LSB first, optional parity, STOP_BITS stop bits,
// each bit held for BAUD_DIV clocks. Queued words go out with no idle gap.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  uart_tx_fifo_param_if.slave          i_bus,
  output logic                         o_tx,
  output logic                         o_tx_busy,
  output logic                         o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);
  localparam int unsigned BW       = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BaudLast = BW'(BAUD_DIV - 1);
  localparam logic [3:0]  DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]  StopLast = 4'(STOP_BITS - 1);
  localparam logic        ParOdd   = (PARITY_ODD != 0);

  tx_state_t            r_state;
  logic [BW-1:0]        r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic [DATA_BITS-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_tick;
  logic                 w_last_stop;
  logic                 w_pop;

  // tx_ready depends on occupancy only, never on a same-cycle pop.
  assign i_bus.tx_ready = !w_full;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_bus.tx_valid),
    .i_data  (i_bus.tx_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (o_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_tick      = (r_baud == BaudLast);
  assign w_last_stop = (r_state == StStop) && w_tick && (r_bit == StopLast);
  // Pop from idle, or at the end of the last stop bit for a zero-gap follow-on frame.
  assign w_pop       = !w_empty && ((r_state == StIdle) || w_last_stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != StIdle) r_baud <= w_tick ? '0 : r_baud + 1'b1;

      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_state <= StStart;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        StStart: begin
          if (w_tick) begin
            r_state <= StData;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_bit == DataLast) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_state <= StParity;
                r_tx    <= r_par;
              end else begin
                r_state <= StStop;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
        StParity: begin
          if (w_tick) begin
            r_state <= StStop;
            r_tx    <= 1'b1;
            r_bit   <= '0;
          end
        end
        StStop: begin
          if (w_tick) begin
            if (r_bit == StopLast) begin
              r_bit  <= '0;
              r_done <= 1'b1;
              if (w_pop) begin
                r_state <= StStart;
                r_tx    <= 1'b0;
              end else begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase

      // Load only happens in idle or at the last stop tick, where the case leaves r_shift alone.
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= par_bit(MAX_DATA_BITS'(w_head), ParOdd);
      end
    end
  end

  assign o_tx      = r_tx;
  assign o_tx_busy = r_busy;
  assign o_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
module tb_uart_tx_fifo_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Per-instance configuration, used by the reference model.
  int p_db   [5] = '{8, 7, 7, 8, 8};
  int p_baud [5] = '{4, 4, 4, 4, 2604};
  int p_pe   [5] = '{0, 1, 1, 0, 0};
  int p_po   [5] = '{0, 0, 1, 0, 0};
  int p_sb   [5] = '{1, 1, 1, 2, 1};

  wire [4:0] tx_w;
  wire [4:0] busy_w;
  wire [4:0] done_w;
  wire [2:0] cnt0, cnt1, cnt2, cnt3, cnt4;

  uart_tx_fifo_param_if #(.DATA_BITS(8)) if0 ();
  uart_tx_fifo_param_if #(.DATA_BITS(7)) if1 ();
  uart_tx_fifo_param_if #(.DATA_BITS(7)) if2 ();
  uart_tx_fifo_param_if #(.DATA_BITS(8)) if3 ();
  uart_tx_fifo_param_if #(.DATA_BITS(8)) if4 ();

  uart_tx_fifo_param #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .i_bus(if0), .o_tx(tx_w[0]), .o_tx_busy(busy_w[0]),
    .o_tx_done(done_w[0]), .o_fifo_count(cnt0));
  uart_tx_fifo_param #(.DATA_BITS(7), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(0),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .i_bus(if1), .o_tx(tx_w[1]), .o_tx_busy(busy_w[1]),
    .o_tx_done(done_w[1]), .o_fifo_count(cnt1));
  uart_tx_fifo_param #(.DATA_BITS(7), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .i_bus(if2), .o_tx(tx_w[2]), .o_tx_busy(busy_w[2]),
    .o_tx_done(done_w[2]), .o_fifo_count(cnt2));
  uart_tx_fifo_param #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY_EN(0), .PARITY_ODD(0),
                       .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst_n(rst_n), .i_bus(if3), .o_tx(tx_w[3]), .o_tx_busy(busy_w[3]),
    .o_tx_done(done_w[3]), .o_fifo_count(cnt3));
  uart_tx_fifo_param u4 (
    .clk(clk), .rst_n(rst_n), .i_bus(if4), .o_tx(tx_w[4]), .o_tx_busy(busy_w[4]),
    .o_tx_done(done_w[4]), .o_fifo_count(cnt4));

  logic [2:0] sel = 3'd0;
  wire tx_s   = tx_w[sel];
  wire busy_s = busy_w[sel];
  wire done_s = done_w[sel];

  bit exp_q[$];
  bit got_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference frame: start, data LSB first, parity over the data ones count, stop bits.
  task automatic build(input int inst, input logic [8:0] d);
    int ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < p_db[inst]; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (p_pe[inst] != 0) exp_q.push_back(((ones % 2) == 1) ^ (p_po[inst] != 0));
    for (int i = 0; i < p_sb[inst]; i++) exp_q.push_back(1'b1);
  endtask

  task automatic drive(input int inst, input logic v, input logic [8:0] d);
    case (inst)
      0: begin if0.tx_valid = v; if0.tx_data = d[7:0]; end
      1: begin if1.tx_valid = v; if1.tx_data = d[6:0]; end
      2: begin if2.tx_valid = v; if2.tx_data = d[6:0]; end
      3: begin if3.tx_valid = v; if3.tx_data = d[7:0]; end
      default: begin if4.tx_valid = v; if4.tx_data = d[7:0]; end
    endcase
  endtask

  function automatic logic rdy(input int inst);
    case (inst)
      0: return if0.tx_ready;
      1: return if1.tx_ready;
      2: return if2.tx_ready;
      3: return if3.tx_ready;
      default: return if4.tx_ready;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input int inst, input logic [8:0] d);
    int t = 0;
    drive(inst, 1'b1, d);
    while (!rdy(inst) && t < 5000) begin @(negedge clk); t++; end
    if (!rdy(inst)) chk("push_ready_timeout", int'(rdy(inst)), 1);
    @(negedge clk);
    drive(inst, 1'b0, d);
  endtask

  // Follows one frame of the selected instance against exp_q, cycle by cycle.
  task automatic run_frame(input string nm, input int baud, input bit b2b,
                           output int waited, output int len);
    int t = 0;
    int dn = 0;
    bit busy_bad = 0;
    got_q.delete();
    waited = 0;
    len = -1;
    while (tx_s !== 1'b0 && waited < 3000) begin @(negedge clk); waited++; end
    if (tx_s !== 1'b0) begin
      chk({nm, "_start_timeout"}, int'(tx_s), 0);
      return;
    end
    if (b2b) chk({nm, "_gap"}, waited, 0);
    foreach (exp_q[b]) begin
      int obs = exp_q[b];
      for (int c = 0; c < baud; c++) begin
        if (t > 0) @(negedge clk);
        if (tx_s !== exp_q[b]) obs = int'(tx_s);
        if (busy_s !== 1'b1) busy_bad = 1;
        if (t > 0 && done_s === 1'b1) dn++;
        if (c == baud / 2) got_q.push_back(tx_s);
        t++;
      end
      chk($sformatf("%s_bit%0d", nm, b), obs, int'(exp_q[b]));
    end
    chk({nm, "_busy"}, int'(busy_bad), 0);
    chk({nm, "_early_done"}, dn, 0);
    len = t;
    @(negedge clk);
    while (done_s !== 1'b1 && len < t + 8) begin @(negedge clk); len++; end
  endtask

  typedef struct {
    int         inst;
    logic [8:0] data;
    int         exp_par;
    int         exp_len;
  } vec_t;
  vec_t vecs[6];

  int w, len;
  logic [8:0] words[8];
  int max_cnt = 0;
  bit mon_en = 0, saw_stall = 0, ready_bad = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(cnt0) > max_cnt) max_cnt = int'(cnt0);
      if (!if0.tx_ready) saw_stall = 1;
      if (if0.tx_ready !== (cnt0 < 3'd4)) ready_bad = 1;
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) drive(i, 1'b0, 9'h0);
    vecs[0] = '{0, 9'h0A5, -1, 40};
    vecs[1] = '{1, 9'h007,  1, 40};
    vecs[2] = '{2, 9'h007,  0, 40};
    vecs[3] = '{1, 9'h055,  0, 40};
    vecs[4] = '{2, 9'h055,  1, 40};
    vecs[5] = '{0, 9'h03C, -1, 40};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx_w[0]), 1);
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_ready", int'(if0.tx_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx", int'(tx_w), 5'h1F);
    chk("post_rst_busy", int'(busy_w), 0);
    chk("post_rst_done", int'(done_w), 0);
    chk("post_rst_cnt", int'(cnt0), 0);
    chk("post_rst_cnt4", int'(cnt4), 0);

    // Table: single frames from idle, incl. parity cases
    for (int v = 0; v < 6; v++) begin
      sel = 3'(vecs[v].inst);
      build(vecs[v].inst, vecs[v].data);
      push(vecs[v].inst, vecs[v].data);
      run_frame($sformatf("vec%0d", v), p_baud[vecs[v].inst], 0, w, len);
      chk($sformatf("vec%0d_pop_latency", v), w, 1);
      chk($sformatf("vec%0d_len", v), len, vecs[v].exp_len);
      chk($sformatf("vec%0d_idle_busy", v), int'(busy_s), 0);
      if (vecs[v].exp_par >= 0)
        chk($sformatf("vec%0d_parity", v), int'(got_q[1 + p_db[vecs[v].inst]]), vecs[v].exp_par);
      repeat (5) @(negedge clk);
    end

    // Two stop bits, back-to-back frames
    sel = 3'd3;
    push(3, 9'h000);
    push(3, 9'h0FF);
    build(3, 9'h000);
    run_frame("t3a", 4, 0, w, len);
    chk("t3a_len", len, 44);
    build(3, 9'h0FF);
    run_frame("t3b", 4, 1, w, len);
    chk("t3b_len", len, 44);
    chk("t3b_idle_busy", int'(busy_s), 0);

    // FIFO fill with valid held high, random words
    sel = 3'd0;
    for (int i = 0; i < 8; i++) words[i] = 9'($urandom_range(0, 255));
    mon_en = 1;
    fork
      begin
        for (int i = 0; i < 6; i++) push(0, words[i]);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          build(0, words[i]);
          run_frame($sformatf("fill%0d", i), 4, i > 0, w, len);
          chk($sformatf("fill%0d_len", i), len, 40);
        end
      end
    join
    mon_en = 0;
    chk("fill_max_count", max_cnt, 4);
    chk("fill_ready_dropped", int'(saw_stall), 1);
    chk("fill_ready_rule", int'(ready_bad), 0);
    repeat (5) @(negedge clk);

    // Random gaps between pushes
    for (int i = 0; i < 8; i++) words[i] = 9'($urandom_range(0, 255));
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(0, 60)) @(negedge clk);
          push(0, words[i]);
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          build(0, words[i]);
          run_frame($sformatf("rnd%0d", i), 4, 0, w, len);
          chk($sformatf("rnd%0d_len", i), len, 40);
        end
      end
    join
    repeat (5) @(negedge clk);

    // Reset mid-DATA with two words queued
    push(0, 9'h03C);
    push(0, 9'($urandom_range(0, 255)));
    push(0, 9'($urandom_range(0, 255)));
    w = 0;
    while (busy_w[0] !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    repeat (10) @(negedge clk);
    chk("mid_busy", int'(busy_w[0]), 1);
    chk("mid_cnt", int'(cnt0), 2);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", int'(tx_w[0]), 1);
    chk("abort_busy", int'(busy_w[0]), 0);
    chk("abort_cnt", int'(cnt0), 0);
    chk("abort_ready", int'(if0.tx_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    begin
      int lows = 0;
      int busys = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (tx_w[0] !== 1'b1) lows++;
        if (busy_w[0] !== 1'b0) busys++;
      end
      chk("after_abort_tx_low_cycles", lows, 0);
      chk("after_abort_busy_cycles", busys, 0);
    end

    // Default parameters
    sel = 3'd4;
    build(4, 9'h055);
    push(4, 9'h055);
    run_frame("dflt", 2604, 0, w, len);
    chk("dflt_pop_latency", w, 1);
    chk("dflt_len", len, p_baud[4] * (1 + p_db[4] + p_pe[4] + p_sb[4]));
    chk("dflt_idle_busy", int'(busy_s), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1/19200 TX block. Data width, baud divisor, parity and stop-bit count are set by parameters. A small input FIFO with valid/ready handshake decouples the producer, so frames go out back-to-back. It sits between the command/telemetry logic and the board's serial TX pin.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9)
BAUD_DIV, 2604, clocks per bit (50 MHz / 19200); must be ≥ 2
PARITY_EN, 0, 1 = insert parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_DEPTH, 4, input FIFO entries; power of two, ≥ 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
tx_data  input  DATA_BITS  byte/word to send
tx_valid  input  1  producer offers tx_data
tx_ready  output  1  FIFO can accept; push occurs when tx_valid && tx_ready
tx  output  1  serial line, idle high
tx_busy  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse at end of each frame's last stop bit
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, rst_n = 0): tx = 1, tx_busy = 0, tx_done = 0, tx_ready = 1, fifo_count = 0.
  - FIFO contents discarded, FSM forced to IDLE, baud and bit counters cleared.
  - Reset mid-frame aborts the frame; tx returns high immediately (no waiting for a clock edge).
- FIFO push: on a cycle with tx_valid && tx_ready.
  - tx_ready = (fifo_count < FIFO_DEPTH), a function of count only; it does not look ahead to a same-cycle pop.
  - A push while full cannot happen; tx_valid with tx_ready = 0 is simply held off and no data is lost.
  - Push and pop in the same cycle: count is unchanged.
  - Push into an empty FIFO: the pop happens on the next cycle at the earliest (no bypass).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register and go to START. tx drops low on the cycle after the pop.
  - Each bit state holds its tx value for exactly BAUD_DIV clocks. A baud counter runs 0..BAUD_DIV-1; the bit ends at the tick where it equals BAUD_DIV-1.
  - START: tx = 0 → DATA.
  - DATA: tx = shift LSB first; DATA_BITS bits, then go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the data bits, XOR PARITY_ODD → STOP.
  - STOP: tx = 1 for STOP_BITS bit periods.
- End of the final stop bit:
  - tx_done pulses for 1 cycle.
  - If the FIFO is non-empty, pop and go to START directly, giving zero idle gap between frames; otherwise go to IDLE.
- tx_busy = 1 in every state except IDLE.
- Frame length = BAUD_DIV × (1 + DATA_BITS + PARITY_EN + STOP_BITS) clocks, e.g. 26040 at the defaults.
- Counter widths: baud counter $clog2(BAUD_DIV); bit counter 4 bits.
- FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked in fifo_count, which is one bit wider than the pointers, to distinguish full from empty.
- tx comes straight from a flop (glitch-free).

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - localparam defaults DEF_BAUD_DIV = 2604 and DEF_DATA_BITS = 8;
  - a function par_bit(data, odd) for parity.
- Natural sub-module: uart_tx_fifo (synchronous FIFO, WIDTH/DEPTH parameters, push/pop/count/full/empty).
- The FSM, baud counter, bit counter and shift register stay in the top module.

Test Plan:
1. BAUD_DIV = 4, 8N1: push 0xA5 into an idle block.
   - tx low for 4 clocks, then 1,0,1,0,0,1,0,1 at 4 clocks each, then high for 4 clocks.
   - tx_done pulses once, 40 clocks after tx first falls.
2. PARITY_EN = 1, even, DATA_BITS = 7: push 0x07.
   - Parity bit = 1.
   - Repeat with PARITY_ODD = 1: parity bit = 0.
3. STOP_BITS = 2, BAUD_DIV = 4: push 0x00 then 0xFF.
   - Stop is high for 8 clocks.
   - The second start bit begins on the very next clock (zero gap); 2 tx_done pulses.
4. FIFO_DEPTH = 4: hold tx_valid high with 6 words while the line is busy.
   - tx_ready drops after the FIFO fills (fifo_count = 4).
   - All 6 words are transmitted in order; none lost or duplicated.
5. Assert rst_n low mid-DATA of 0x3C with 2 words queued.
   - tx = 1 immediately; tx_busy = 0, fifo_count = 0.
   - After release, tx stays high with no residual frame.
6. Default parameters: push 0x55.
   - Each bit lasts exactly 2604 clocks; the frame is 26040 clocks.
